// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the CPU data-SRAM responder: MMIO page selector and register offsets.
// The same offsets are used by the SoC top and by test programs running on the CPU.
// Contents: MMIO_HI_DEF, *_OFS offsets, mmio_sel_e register select, mmio_decode().
package data_sram_responder_pkg;

  localparam int          RAM_AW_DEF   = 14;
  localparam int          SW_WIDTH_DEF = 8;
  localparam logic [15:0] MMIO_HI_DEF  = 16'hBFAF;

  localparam logic [15:0] LED_OFS   = 16'hF000;
  localparam logic [15:0] NUM_OFS   = 16'hF010;
  localparam logic [15:0] SW_OFS    = 16'hF020;
  localparam logic [15:0] TIMER_OFS = 16'hE000;

  typedef enum logic [2:0] {
    MM_NONE,
    MM_LED,
    MM_NUM,
    MM_SW,
    MM_TIMER
  } mmio_sel_e;

  // Byte offset within the MMIO page -> register; addr[1:0] is ignored.
  function automatic mmio_sel_e mmio_decode(input logic [15:0] ofs);
    mmio_sel_e sel;
    case ({ofs[15:2], 2'b00})
      LED_OFS:   sel = MM_LED;
      NUM_OFS:   sel = MM_NUM;
      SW_OFS:    sel = MM_SW;
      TIMER_OFS: sel = MM_TIMER;
      default:   sel = MM_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sram_bytewe_ram.sv
// Single-port read-first RAM, 4 byte lanes, registered read port (infers block RAM).
// Latency: 1 cycle; rdata updates only on en=1 and holds otherwise. No backpressure.
// Ports: clk; en (access); we[3:0] (lane write enables); addr[AW-1:0] (word address);
//        wdata[31:0]; rdata[31:0] (pre-write word of the last enabled access).
module sram_bytewe_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1 << AW) - 1];

  // No reset on the array or the output register so the tools can map both into BRAM.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Target side of the CPU data-SRAM port: byte-writable RAM plus LED/NUM/SWITCH/TIMER MMIO.
// Latency: fixed 1 cycle; rdata is valid the cycle after en and held until the next en.
// Backpressure: none, every access is accepted in the cycle it is presented.
// Ports: clk, reset (async, active-high); data_sram_en/we/addr/wdata in, data_sram_rdata out;
//        led, num_data register outputs; switch asynchronous board input.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW   = RAM_AW_DEF,
  parameter logic [15:0] MMIO_HI  = MMIO_HI_DEF,
  parameter int          SW_WIDTH = SW_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_sram_en,
  input  logic [3:0]          data_sram_we,
  input  logic [31:0]         data_sram_addr,
  input  logic [31:0]         data_sram_wdata,
  output logic [31:0]         data_sram_rdata,
  output logic [15:0]         led,
  output logic [31:0]         num_data,
  input  logic [SW_WIDTH-1:0] switch
);

  logic                is_mmio;
  mmio_sel_e           sel;
  logic                mmio_wr;
  logic                ram_en;
  logic [3:0]          ram_we;
  logic [31:0]         ram_rdata;
  logic [31:0]         mmio_rd_val;
  logic [31:0]         mmio_q;
  logic                rd_mmio;
  logic [31:0]         timer;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;

  assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign sel     = mmio_decode(data_sram_addr[15:0]);

  // MMIO registers only accept full-word stores; partial stores are dropped.
  assign mmio_wr = data_sram_en && is_mmio && (data_sram_we == 4'hF);

  // The RAM has no reset, so block its writes explicitly while reset is held.
  assign ram_en = data_sram_en && !is_mmio && !reset;
  assign ram_we = ram_en ? data_sram_we : 4'h0;

  sram_bytewe_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // Current register values: a read in the same cycle as a write sees the old value.
  always_comb begin
    mmio_rd_val = 32'h0;
    case (sel)
      MM_LED:   mmio_rd_val = {16'h0, led};
      MM_NUM:   mmio_rd_val = num_data;
      MM_SW:    mmio_rd_val = 32'(sw_sync);
      MM_TIMER: mmio_rd_val = timer;
      default:  mmio_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= 16'h0;
      num_data <= 32'h0;
      timer    <= 32'h0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      mmio_q   <= 32'h0;
      rd_mmio  <= 1'b1;  // selects mmio_q (zero) so rdata reads 0 out of reset
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;

      // A timer write stands in for this cycle's tick, so the next cycle sees wdata+1.
      if (mmio_wr && sel == MM_TIMER) begin
        timer <= data_sram_wdata + 32'd1;
      end else begin
        timer <= timer + 32'd1;
      end

      if (mmio_wr && sel == MM_LED) begin
        led <= data_sram_wdata[15:0];
      end
      if (mmio_wr && sel == MM_NUM) begin
        num_data <= data_sram_wdata;
      end

      // Region select travels with the request to steer the cycle-N+1 mux.
      if (data_sram_en) begin
        rd_mmio <= is_mmio;
        mmio_q  <= is_mmio ? mmio_rd_val : 32'h0;
      end
    end
  end

  assign data_sram_rdata = rd_mmio ? mmio_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios plus randomized traffic
// compared against a behavioural model (word-indexed memory, register variables, cycle timer).
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .num_data        (num_data),
    .switch          (switch)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state (values visible during the current cycle).
  logic [31:0] mem_m [int];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [31:0] m_rdata;
  logic [7:0]  m_sw_prev;   // switch value sampled one edge ago
  logic [7:0]  m_sw_seen;   // switch value sampled two edges ago (what software sees)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [15:0] o;
    int          idx;
    o   = {a[15:2], 2'b00};
    idx = int'(a[15:2]);
    if (a[31:16] == 16'hBFAF) begin
      if (o == 16'hF000) return {16'h0, m_led};
      if (o == 16'hF010) return m_num;
      if (o == 16'hF020) return {24'h0, m_sw_seen};
      if (o == 16'hE000) return m_timer;
      return 32'h0;
    end
    if (mem_m.exists(idx)) return mem_m[idx];
    return 'x;
  endfunction

  task automatic model_reset();
    m_led     = 16'h0;
    m_num     = 32'h0;
    m_timer   = 32'h0;
    m_rdata   = 32'h0;
    m_sw_prev = 8'h0;
    m_sw_seen = 8'h0;
  endtask

  // One clock cycle with the given request; checks rdata/led/num_data after the edge.
  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    logic [31:0] rv;
    logic [15:0] o;
    logic        mm;
    logic        full;
    int          idx;
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    rv    = model_read(a);
    o     = {a[15:2], 2'b00};
    mm    = (a[31:16] == 16'hBFAF);
    full  = e && mm && (w == 4'hF);
    idx   = int'(a[15:2]);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (e) m_rdata = rv;
      if (full && o == 16'hE000) m_timer = d + 32'd1;
      else                       m_timer = m_timer + 32'd1;
      if (full && o == 16'hF000) m_led = d[15:0];
      if (full && o == 16'hF010) m_num = d;
      if (e && !mm && w != 4'h0) begin
        if (!mem_m.exists(idx)) mem_m[idx] = 'x;
        for (int i = 0; i < 4; i++) begin
          if (w[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
      m_sw_seen = m_sw_prev;
      m_sw_prev = switch;
    end
    #1;
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
    check({tag, "_num"}, num_data, m_num);
  endtask

  initial begin
    logic [15:0] ofs_tbl [6];
    logic [15:0] hi;
    logic [3:0]  wsel;
    logic [31:0] a;
    int          r;

    ofs_tbl[0] = 16'hF000; ofs_tbl[1] = 16'hF010; ofs_tbl[2] = 16'hF020;
    ofs_tbl[3] = 16'hE000; ofs_tbl[4] = 16'hF040; ofs_tbl[5] = 16'h0000;

    // Reset state.
    reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; switch = 8'h0;
    model_reset();
    #2;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    req(1'b0, 4'h0, 32'h0, 32'h0, "rst_hold0");
    req(1'b0, 4'h0, 32'h0, 32'h0, "rst_hold1");
    reset = 1'b0;

    // 1: full write then read.
    req(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "t1_wr");
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, "t1_rd");
    check("t1_const", rdata, 32'hDEAD_BEEF);

    // 2: single-lane write, read-first return value.
    req(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_5500, "t2_wr");
    check("t2_readfirst", rdata, 32'hDEAD_BEEF);
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, "t2_rd");
    check("t2_const", rdata, 32'hDEAD_55EF);

    // 3: LED register, partial-byte MMIO write dropped.
    req(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_ABCD, "t3_wr");
    check("t3_led", {16'h0, led}, 32'h0000_ABCD);
    req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0, "t3_rd");
    check("t3_rd_const", rdata, 32'h0000_ABCD);
    req(1'b1, 4'b0001, 32'hBFAF_F000, 32'h0000_00FF, "t3_part");
    check("t3_led_kept", {16'h0, led}, 32'h0000_ABCD);
    req(1'b1, 4'hF, 32'hBFAF_F010, 32'hCAFE_F00D, "t3_num");
    check("t3_num_const", num_data, 32'hCAFE_F00D);

    // 4: timer load and wrap.
    req(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, "t4_wr");
    req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0, "t4_rd0");
    check("t4_const0", rdata, 32'hFFFF_FFFF);
    req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0, "t4_rd1");
    check("t4_const1", rdata, 32'h0000_0000);

    // 5: switch synchroniser lag.
    switch = 8'hA5;
    req(1'b1, 4'h0, 32'hBFAF_F020, 32'h0, "t5_T0");
    check("t5_T0_const", rdata, 32'h0);
    req(1'b1, 4'h0, 32'hBFAF_F020, 32'h0, "t5_T1");
    check("t5_T1_const", rdata, 32'h0);
    req(1'b1, 4'h0, 32'hBFAF_F020, 32'h0, "t5_T2");
    check("t5_T2_const", rdata, 32'h0000_00A5);

    // Randomized traffic over 16 RAM words (with aliased upper address bits) and MMIO.
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 4'hF, 32'(i * 4), $urandom, "init");
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0)      wsel = 4'h0;
      else if (r == 1) wsel = 4'h0;
      else if (r == 2) wsel = 4'hF;
      else             wsel = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 5) begin
        hi = 16'($urandom);
        if (hi == 16'hBFAF) hi = 16'h0;
        a = {hi, 10'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      end else begin
        a = {16'hBFAF, ofs_tbl[$urandom_range(0, 5)] | 16'($urandom_range(0, 3))};
      end
      req(($urandom_range(0, 4) != 0), wsel, a, $urandom, "rnd");
    end

    // 6: asynchronous reset with live state; RAM survives, unmapped MMIO reads 0.
    req(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_ABCD, "t6_led");
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, "t6_rd");
    check("t6_pre_rdata", rdata, 32'hDEAD_55EF);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_rdata", rdata, 32'h0);
    check("t6_async_led", {16'h0, led}, 32'h0);
    check("t6_async_num", num_data, 32'h0);
    req(1'b1, 4'hF, 32'h0000_0100, 32'h1111_1111, "t6_rst_wr");
    reset = 1'b0;
    req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0, "t6_timer");
    check("t6_timer_const", rdata, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0100, 32'h0, "t6_ram");
    check("t6_ram_const", rdata, 32'hDEAD_55EF);
    req(1'b1, 4'hF, 32'hBFAF_F040, 32'h5A5A_5A5A, "t6_unm_wr");
    req(1'b1, 4'h0, 32'hBFAF_F040, 32'h0, "t6_unm_rd");
    check("t6_unm_const", rdata, 32'h0);
    req(1'b0, 4'h0, 32'h0000_0100, 32'h0, "t6_idle");
    check("t6_idle_hold", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
